// File: rtl/csr_trap_unit_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR / trap unit.
//   - CSR address map
//   - request-kind and CSR-op encodings
//   - mstatus field positions and the writable-bit mask
//   - counter instance indices used by the top level
package csr_pkg;

    // CSR address map
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    typedef enum logic [1:0] {
        REQ_CSR   = 2'd0,
        REQ_ECALL = 2'd1,
        REQ_MRET  = 2'd2,
        REQ_RSVD  = 2'd3
    } req_kind_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RW   = 2'd1,
        OP_RS   = 2'd2,
        OP_RC   = 2'd3
    } csr_op_e;

    // mstatus fields
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Only MIE and MPIE are storage; MPP is hard-wired to machine mode.
    localparam logic [31:0] MSTATUS_WMASK  = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_MPP_RO = 32'h0000_1800;

    // Indices into the counter instance array
    localparam int CNT_MCYCLE   = 0;
    localparam int CNT_MINSTRET = 1;
    localparam int NUM_CNT      = 2;

    // Addresses with addr[11:10]==2'b11 are read-only by encoding.
    function automatic logic csr_is_readonly(input logic [11:0] addr);
        return (addr[11:10] == 2'b11);
    endfunction

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// csr_counter64: 64-bit performance counter split into 32-bit halves.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   inc_i          - advance the counter by one this cycle
//   wr_lo_i        - load the low half from wdata_i (wins over increment)
//   wr_hi_i        - load the high half from wdata_i (wins over carry)
//   wdata_i        - write data for either half
//   value_o        - current {hi, lo} value
module csr_counter64 (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        carry;

    // The low half wraps on this increment.
    assign carry = inc_i & (lo_q == 32'hFFFF_FFFF);

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (wr_lo_i) begin
            lo_d = wdata_i;
        end else if (inc_i) begin
            lo_d = lo_q + 32'd1;
        end
        // A written low half never produced a wrap, so its carry is void.
        if (wr_hi_i) begin
            hi_d = wdata_i;
        end else if (carry && !wr_lo_i) begin
            hi_d = hi_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lo_q <= 32'd0;
            hi_q <= 32'd0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign value_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with ecall/mret sequencing.
// One request is accepted per in_valid/in_ready handshake; the response
// (old CSR value, illegal flag, PC redirect) is registered and held on
// out_valid until out_ready. All state changes commit on the accept edge,
// so a following request always observes them.
// Ports:
//   clock, reset                   - clock, synchronous active-high reset
//   in_valid/in_ready              - request handshake
//   req_kind, csr_op, csr_addr     - request decode
//   csr_wsrc                       - rs1 value / zero-extended zimm
//   trap_cause, trap_pc            - ecall cause and trapping PC
//   out_valid/out_ready            - response handshake
//   out_rdata, out_illegal         - old CSR value, illegal-request flag
//   redirect_valid, redirect_pc    - one-cycle PC redirect for ecall/mret
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int          XLEN          = 32,
    parameter logic [31:0] MVENDORID_VAL = 32'h7973_7978,
    parameter logic [31:0] MARCHID_VAL   = 32'h017E_3F5D,
    parameter logic [31:0] MTVEC_RESET   = 32'h0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      req_kind,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wsrc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    // Clears the low two bits of mtvec/mepc (direct mode, 4-byte aligned).
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // Architectural state
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mtvec_q,   mtvec_d;
    logic [XLEN-1:0] mepc_q,    mepc_d;
    logic [XLEN-1:0] mcause_q,  mcause_d;

    // Output stage
    logic            out_valid_q,      out_valid_d;
    logic [XLEN-1:0] out_rdata_q,      out_rdata_d;
    logic            out_illegal_q,    out_illegal_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q,    redirect_pc_d;

    // Decode
    req_kind_e       kind;
    csr_op_e         op;
    logic            accept;
    logic            addr_mapped;
    logic            do_write;
    logic            illegal;
    logic            csr_wr_en;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;

    // Counters
    logic [NUM_CNT-1:0] cnt_inc;
    logic [NUM_CNT-1:0] cnt_wr_lo;
    logic [NUM_CNT-1:0] cnt_wr_hi;
    logic [63:0]        cnt_val [NUM_CNT];

    assign kind     = req_kind_e'(req_kind);
    assign op       = csr_op_e'(csr_op);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Read mux: value before any same-edge update.
    always_comb begin
        old_val     = '0;
        addr_mapped = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:   old_val = (mstatus_q & MSTATUS_WMASK) | MSTATUS_MPP_RO;
            CSR_MTVEC:     old_val = mtvec_q & ALIGN_MASK;
            CSR_MEPC:      old_val = mepc_q & ALIGN_MASK;
            CSR_MCAUSE:    old_val = mcause_q;
            CSR_MCYCLE:    old_val = cnt_val[CNT_MCYCLE][31:0];
            CSR_MCYCLEH:   old_val = cnt_val[CNT_MCYCLE][63:32];
            CSR_MINSTRET:  old_val = cnt_val[CNT_MINSTRET][31:0];
            CSR_MINSTRETH: old_val = cnt_val[CNT_MINSTRET][63:32];
            CSR_MVENDORID: old_val = MVENDORID_VAL;
            CSR_MARCHID:   old_val = MARCHID_VAL;
            default:       addr_mapped = 1'b0;
        endcase
    end

    // RS/RC with a zero source are pure reads, so they may target
    // read-only CSRs without being illegal.
    always_comb begin
        do_write = 1'b0;
        new_val  = old_val;
        case (op)
            OP_RW: begin
                do_write = 1'b1;
                new_val  = csr_wsrc;
            end
            OP_RS: begin
                do_write = (csr_wsrc != '0);
                new_val  = old_val | csr_wsrc;
            end
            OP_RC: begin
                do_write = (csr_wsrc != '0);
                new_val  = old_val & ~csr_wsrc;
            end
            default: begin
                do_write = 1'b0;
                new_val  = old_val;
            end
        endcase
    end

    always_comb begin
        illegal = 1'b0;
        if (kind == REQ_RSVD) begin
            illegal = 1'b1;
        end else if (kind == REQ_CSR) begin
            illegal = !addr_mapped || (do_write && csr_is_readonly(csr_addr));
        end
    end

    assign csr_wr_en = accept && !illegal && (kind == REQ_CSR) && do_write;

    // CSR / trap state update
    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        if (csr_wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: mstatus_d = new_val & MSTATUS_WMASK;
                CSR_MTVEC:   mtvec_d   = new_val & ALIGN_MASK;
                CSR_MEPC:    mepc_d    = new_val & ALIGN_MASK;
                CSR_MCAUSE:  mcause_d  = new_val;
                default:     ;
            endcase
        end
        if (accept && kind == REQ_ECALL) begin
            mepc_d                  = trap_pc & ALIGN_MASK;
            mcause_d                = trap_cause;
            mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
            mstatus_d[MSTATUS_MIE]  = 1'b0;
        end
        if (accept && kind == REQ_MRET) begin
            mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE] = 1'b1;
        end
    end

    // Output stage: payload only loads on accept and is held under stall;
    // redirect_valid is a single-cycle pulse for the PC unit.
    always_comb begin
        out_valid_d      = out_valid_q && !out_ready;
        out_rdata_d      = out_rdata_q;
        out_illegal_d    = out_illegal_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_illegal_d = illegal;
            out_rdata_d   = (kind == REQ_CSR && !illegal) ? old_val : '0;
            if (kind == REQ_ECALL) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = mtvec_q & ALIGN_MASK;
            end else if (kind == REQ_MRET) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = mepc_q & ALIGN_MASK;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mstatus_q        <= '0;
            mtvec_q          <= MTVEC_RESET & ALIGN_MASK;
            mepc_q           <= '0;
            mcause_q         <= '0;
            out_valid_q      <= 1'b0;
            out_rdata_q      <= '0;
            out_illegal_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mstatus_q        <= mstatus_d;
            mtvec_q          <= mtvec_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            out_valid_q      <= out_valid_d;
            out_rdata_q      <= out_rdata_d;
            out_illegal_q    <= out_illegal_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Counter controls: mcycle free-runs, minstret counts retired requests.
    assign cnt_inc[CNT_MCYCLE]     = 1'b1;
    assign cnt_inc[CNT_MINSTRET]   = accept && !illegal;
    assign cnt_wr_lo[CNT_MCYCLE]   = csr_wr_en && (csr_addr == CSR_MCYCLE);
    assign cnt_wr_hi[CNT_MCYCLE]   = csr_wr_en && (csr_addr == CSR_MCYCLEH);
    assign cnt_wr_lo[CNT_MINSTRET] = csr_wr_en && (csr_addr == CSR_MINSTRET);
    assign cnt_wr_hi[CNT_MINSTRET] = csr_wr_en && (csr_addr == CSR_MINSTRETH);

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            csr_counter64 u_cnt (
                .clock   (clock),
                .reset   (reset),
                .inc_i   (cnt_inc[gi]),
                .wr_lo_i (cnt_wr_lo[gi]),
                .wr_hi_i (cnt_wr_hi[gi]),
                .wdata_i (new_val[31:0]),
                .value_o (cnt_val[gi])
            );
        end
    endgenerate

    assign out_valid      = out_valid_q;
    assign out_rdata      = out_rdata_q;
    assign out_illegal    = out_illegal_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
module tb_csr_trap_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  req_kind;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wsrc;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clock = ~clock;

    csr_trap_unit dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .req_kind       (req_kind),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wsrc       (csr_wsrc),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_illegal    (out_illegal),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        bit          chk_rdata;
        logic        ill;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   passed  = 0;
    int   instret = 0;
    exp_t mon_e;

    // Monitor: one comparison per output handshake.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_output: got rdata=%h ill=%b redir=%b, required no output",
                         out_rdata, out_illegal, redirect_valid);
            end else begin
                mon_e = sb.pop_front();
                if ((!mon_e.chk_rdata || out_rdata == mon_e.rdata) &&
                    out_illegal == mon_e.ill && redirect_valid == mon_e.redir &&
                    (!mon_e.redir || redirect_pc == mon_e.rpc)) begin
                    passed++;
                    $display("txn %s: rdata=%h ill=%b redir=%b pc=%h ok", mon_e.name,
                             out_rdata, out_illegal, redirect_valid, redirect_pc);
                end else begin
                    $display("FAIL %s: got rdata=%h ill=%b redir=%b pc=%h, required rdata=%h(chk %0d) ill=%b redir=%b pc=%h",
                             mon_e.name, out_rdata, out_illegal, redirect_valid, redirect_pc,
                             mon_e.rdata, mon_e.chk_rdata, mon_e.ill, mon_e.redir, mon_e.rpc);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got === req) begin
            passed++;
            $display("chk %s: %h ok", nm, got);
        end else begin
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    task automatic push_exp(input string nm, input logic [31:0] er, input bit cr,
                            input logic ei, input logic erd, input logic [31:0] erpc);
        exp_t x;
        x.name = nm; x.rdata = er; x.chk_rdata = cr;
        x.ill = ei; x.redir = erd; x.rpc = erpc;
        sb.push_back(x);
        if (!ei) instret++;
    endtask

    // Issue one request; returns just after the edge on which it was accepted.
    task automatic send(input logic [1:0] k, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] ws, input logic [31:0] cause, input logic [31:0] pc,
                        input string nm, input logic [31:0] er, input bit cr, input logic ei,
                        input logic erd, input logic [31:0] erpc);
        int n;
        req_kind = k; csr_op = op; csr_addr = a; csr_wsrc = ws;
        trap_cause = cause; trap_pc = pc; in_valid = 1'b1;
        push_exp(nm, er, cr, ei, erd, erpc);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL %s_accept_timeout: in_ready stuck 0, required 1", nm);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] er, input string nm);
        send(2'd0, 2'd0, a, 32'd0, 32'd0, 32'd0, nm, er, 1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic cop(input logic [1:0] op, input logic [11:0] a, input logic [31:0] ws,
                       input logic [31:0] er, input bit cr, input string nm);
        send(2'd0, op, a, ws, 32'd0, 32'd0, nm, er, cr, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic bad(input logic [1:0] k, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] ws, input string nm);
        send(k, op, a, ws, 32'd0, 32'd0, nm, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        req_kind = 2'd0; csr_op = 2'd0; csr_addr = 12'd0; csr_wsrc = 32'd0;
        trap_cause = 32'd0; trap_pc = 32'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_rdata", out_rdata, 32'd0);
        check("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic reads
        rd(12'h300, 32'h0000_1800, "rd_mstatus_rst");
        rd(12'hF11, 32'h7973_7978, "rd_mvendorid");

        // mtvec WARL
        cop(2'd1, 12'h305, 32'h8000_0103, 32'h0, 1'b1, "rw_mtvec");
        cop(2'd2, 12'h305, 32'h1, 32'h8000_0100, 1'b1, "rs_mtvec");
        rd(12'h305, 32'h8000_0100, "rd_mtvec");

        // Trap / return
        cop(2'd2, 12'h300, 32'h8, 32'h0000_1800, 1'b1, "rs_mstatus_mie");
        send(2'd1, 2'd0, 12'h0, 32'd0, 32'd11, 32'h8000_0046, "ecall",
             32'd0, 1'b1, 1'b0, 1'b1, 32'h8000_0100);
        rd(12'h341, 32'h8000_0044, "rd_mepc");
        rd(12'h342, 32'd11, "rd_mcause");
        rd(12'h300, 32'h0000_1880, "rd_mstatus_trap");
        send(2'd2, 2'd0, 12'h0, 32'd0, 32'd0, 32'd0, "mret",
             32'd0, 1'b1, 1'b0, 1'b1, 32'h8000_0044);
        rd(12'h300, 32'h0000_1888, "rd_mstatus_mret");

        // Illegal accesses leave minstret untouched
        rd(12'hB02, instret, "rd_minstret_a");
        bad(2'd0, 2'd1, 12'hF12, 32'h1234, "rw_marchid_ill");
        bad(2'd0, 2'd1, 12'h7C0, 32'h1, "rw_unmapped_ill");
        bad(2'd3, 2'd0, 12'h300, 32'h0, "kind3_ill");
        cop(2'd2, 12'hF12, 32'h0, 32'h017E_3F5D, 1'b1, "rs0_marchid");
        rd(12'hB02, instret, "rd_minstret_b");

        // mcycle low wrap carries into high half (back-to-back requests)
        cop(2'd1, 12'hB00, 32'hFFFF_FFFE, 32'h0, 1'b0, "rw_mcycle");
        rd(12'hB00, 32'hFFFF_FFFE, "mcycle_lo_fe");
        rd(12'hB80, 32'h0, "mcycle_hi_pre");
        rd(12'hB00, 32'h0, "mcycle_lo_wrapped");
        rd(12'hB80, 32'h1, "mcycle_hi_carried");

        // high-half write colliding with low wrap
        cop(2'd1, 12'hB00, 32'hFFFF_FFFE, 32'h0, 1'b0, "rw_mcycle_2");
        rd(12'hB00, 32'hFFFF_FFFE, "mcycle_lo_fe_2");
        cop(2'd1, 12'hB80, 32'h55, 32'h1, 1'b1, "rw_mcycleh_wrap");
        rd(12'hB80, 32'h55, "mcycle_hi_written");
        rd(12'hB00, 32'h1, "mcycle_lo_after_wrap");

        // low-half write suppresses the carry it would have produced
        cop(2'd1, 12'hB00, 32'hFFFF_FFFE, 32'h0, 1'b0, "rw_mcycle_3");
        rd(12'hB00, 32'hFFFF_FFFE, "mcycle_lo_fe_3");
        cop(2'd1, 12'hB00, 32'h7, 32'hFFFF_FFFF, 1'b1, "rw_mcycle_nocarry");
        rd(12'hB80, 32'h55, "mcycle_hi_nocarry");
        rd(12'hB00, 32'h8, "mcycle_lo_written");

        // Backpressure: stall with a second request waiting
        repeat (2) @(posedge clock);
        #1 out_ready = 1'b0;
        req_kind = 2'd0; csr_op = 2'd0; csr_addr = 12'h342; csr_wsrc = 32'd0;
        in_valid = 1'b1;
        push_exp("bp_first", 32'd11, 1'b1, 1'b0, 1'b0, 32'd0);
        @(posedge clock); #1;
        csr_addr = 12'hF11;
        push_exp("bp_second", 32'h7973_7978, 1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_rdata", out_rdata, 32'd11);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        rd(12'hB02, instret, "rd_minstret_bp");

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);

        // Reset while a response is pending drops it
        out_ready = 1'b0;
        req_kind = 2'd0; csr_op = 2'd0; csr_addr = 12'h300; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("pending_out_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("reset_drop_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("post_reset_out_valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file with trap/return sequencing for the single-issue core.
- Sits between decode/execute and the PC unit.
- Accepts one CSR, ecall or mret request per handshake and returns the old CSR value.
- Drives a PC redirect for traps and mret; keeps 64-bit mcycle/minstret counters.
- Successor to the fixed 7-entry CSR array: adds read-modify-write ops, illegal-access detection, mstatus MIE/MPIE stacking and a registered valid/ready output stage.

Parameters:
XLEN, 32, datapath width (32 only for RV32; counters always 64-bit split lo/hi)
MVENDORID_VAL, 32'h7973_7978, read-only mvendorid value
MARCHID_VAL, 32'h017E_3F5D, read-only marchid value
MTVEC_RESET, 32'h0, mtvec value after reset

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  unit can accept request
req_kind  in  2  0=csr op, 1=ecall/trap, 2=mret, 3=reserved (illegal)
csr_op  in  2  0=none(read), 1=RW, 2=RS(set), 3=RC(clear)
csr_addr  in  12  CSR address
csr_wsrc  in  XLEN  rs1 value or zimm, zero-extended
trap_cause  in  XLEN  mcause value for trap (11 for ecall-M)
trap_pc  in  XLEN  PC of trapping instruction
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_rdata  out  XLEN  old CSR value (0 for trap/mret/illegal)
out_illegal  out  1  request was illegal, no state change
redirect_valid  out  1  one-cycle pulse with out_valid for trap/mret
redirect_pc  out  XLEN  target PC

Behaviour:
- Accept when in_valid & in_ready; in_ready = !out_valid | out_ready. Latency 1: result registered on the accept edge, out_valid high the next cycle and held until out_ready.
- Reset: out_valid=0, out_rdata=0, out_illegal=0, redirect_valid=0, redirect_pc=0, mstatus=32'h1800, mtvec=MTVEC_RESET, mepc=0, mcause=0, mcycle=0, minstret=0.
- Address map: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0xB00/0xB80 mcycle/mcycleh, 0xB02/0xB82 minstret/minstreth, 0xF11 mvendorid, 0xF12 marchid. Any other address is illegal.
- CSR op new value:
  - RW: wsrc
  - RS: old | wsrc
  - RC: old & ~wsrc
  - none: no write
  - RS/RC with wsrc==0 performs no write.
- Illegal cases:
  - unmapped address
  - write to addr[11:10]==2'b11 (read-only)
  - req_kind==3
  - Response: rdata=0, illegal=1, no CSR/counter change, minstret not incremented.
- WARL fields:
  - mstatus: only MIE[3], MPIE[7] writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - mtvec[1:0] and mepc[1:0] read 0 (direct mode only).
- Trap: mepc<=trap_pc&~3, mcause<=trap_cause, MPIE<=MIE, MIE<=0; redirect_pc=mtvec (pre-update value); redirect_valid=1.
- mret: MIE<=MPIE, MPIE<=1; redirect_pc=mepc; redirect_valid=1.
- mcycle: increments every cycle out of reset. The lo carry into hi happens when lo==32'hFFFF_FFFF.
- minstret: increments once per accepted non-illegal request.
- Counter write collisions:
  - A software write to a counter half takes priority over that half's increment in the same cycle.
  - If lo is written while hi would carry, hi does not carry.
  - If hi is written while lo wraps, hi takes the written value and lo wraps to 0.
- Reads return the value before the same-edge increment.
- Back-to-back requests: the second request sees the first's writes. No forwarding is needed because the write commits at the accept edge.
- Reset mid-transaction: the pending output is dropped and out_valid=0 the next cycle.

Decomposition:
- Package csr_pkg:
  - CSR address localparams
  - req_kind and csr_op encodings
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11)
  - MSTATUS_WMASK
- Sub-module csr_counter64: 64-bit counter with inc, wr_lo, wr_hi, wdata and the carry/collision rules above. Instantiated twice (mcycle, minstret).

Test Plan:
- Reset, then read 0x300 (op none) -> rdata 32'h1800, illegal 0; read 0xF11 -> MVENDORID_VAL.
- RW 0x305 wsrc 32'h8000_0103, then RS 0x305 wsrc 1 -> second rdata 32'h8000_0100, mtvec still 32'h8000_0100.
- Set MIE via RS 0x300 wsrc 8, then ecall with trap_pc 32'h8000_0046 and cause 11:
  - Expect redirect_pc 32'h8000_0100, mepc 32'h8000_0044, mcause 11, mstatus 32'h1880.
  - Then mret -> redirect_pc 32'h8000_0044, mstatus 32'h1888.
- RW 0xF12, RW 0x7C0, req_kind 3 -> illegal 1, rdata 0, minstret unchanged; RS 0xF12 wsrc 0 -> legal, rdata MARCHID_VAL.
- RW 0xB00 wsrc 32'hFFFF_FFFE, wait 2 cycles -> mcycleh increments by 1 and mcycle lo is 0; hi-write collides with lo wrap -> hi takes written value.
- Hold out_ready=0 with in_valid=1 for 3 cycles -> in_ready=0 and outputs stable; then release -> exactly one accept per out handshake.
